fproc_meas_responder: RTL and testbench

Function-processor responder: the far end of the core-side fproc request interface (fproc_en_out / fproc_id out of each proc; fproc_ready / fproc_data back in). Holds the latest qubit measurement bit per readout channel and answers each core's request either immediately, from the stored value, or after waiting for a fresh measurement. One independent responder port per core, so cores never block each other. It sits beside the proc instances and the readout result path, and drives every core's fproc_ready/fproc_data.

---
 rtl/fproc_pkg.sv | 33 +++
 rtl/fproc_core_port.sv | 122 ++++++++++++
 rtl/fproc_meas_responder.sv | 60 ++++++
 tb/tb_fproc_meas_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fproc_pkg.sv
// Shared types and constants for the fproc measurement responder.
// Response words carry three flag bits; everything above them is zero.
package fproc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    WAIT,
    RESP
  } port_state_e;

  localparam int MEAS_BIT    = 0;
  localparam int TIMEOUT_BIT = 1;
  localparam int BADID_BIT   = 2;
  localparam int RESP_FLAG_W = 3;

  // The top bit of an fproc id selects wait-fresh mode.
  function automatic int mode_bit_pos(input int id_width);
    return id_width - 1;
  endfunction

  function automatic logic [RESP_FLAG_W-1:0] resp_flags(input logic meas,
                                                        input logic tmo,
                                                        input logic bad);
    logic [RESP_FLAG_W-1:0] f;
    f              = '0;
    f[MEAS_BIT]    = meas;
    f[TIMEOUT_BIT] = tmo;
    f[BADID_BIT]   = bad;
    return f;
  endfunction

endpackage

// File: rtl/fproc_core_port.sv
// One responder port: accepts a request from a single core and answers it
// either after a fixed latency or when a fresh measurement (or timeout) arrives.
module fproc_core_port
  import fproc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int N_MEAS         = 8,
  parameter int RESP_LATENCY   = 2,
  parameter int TIMEOUT        = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [FPROC_ID_WIDTH-1:0] id_i,
  input  logic [N_MEAS-1:0]         latest_i,
  input  logic [N_MEAS-1:0]         meas_valid_i,
  input  logic [N_MEAS-1:0]         meas_bit_i,
  output logic                      ready_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      busy_o
);

  localparam int CH_W     = FPROC_ID_WIDTH - 1;
  localparam int MODE_POS = mode_bit_pos(FPROC_ID_WIDTH);
  localparam int MW       = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam int DW       = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DW-1:0] DELAY_LOAD   = DW'((RESP_LATENCY > 1) ? (RESP_LATENCY - 2) : 0);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  port_state_e           state_q;
  logic [MW-1:0]         ch_q;
  logic [DW-1:0]         dly_q;
  logic [TW-1:0]         tmo_q;
  logic                  ready_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [CH_W-1:0] req_ch;
  logic [MW-1:0]   req_idx;
  logic            req_mode;
  logic            req_bad;

  assign req_ch   = id_i[CH_W-1:0];
  assign req_idx  = req_ch[MW-1:0];
  assign req_mode = id_i[MODE_POS];
  assign req_bad  = 32'(req_ch) >= 32'(N_MEAS);

  // Bad ids are answered after the normal latency regardless of mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dly_q   <= '0;
      tmo_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_i) begin
            busy_q <= 1'b1;
            ch_q   <= req_idx;
            if (!req_bad && req_mode) begin
              state_q <= WAIT;
              tmo_q   <= '0;
            end else begin
              data_q <= req_bad ? DATA_WIDTH'(resp_flags(1'b0, 1'b0, 1'b1))
                                : DATA_WIDTH'(resp_flags(latest_i[req_idx], 1'b0, 1'b0));
              if (RESP_LATENCY == 1) begin
                state_q <= RESP;
                ready_q <= 1'b1;
              end else begin
                state_q <= DELAY;
                dly_q   <= DELAY_LOAD;
              end
            end
          end
        end
        DELAY: begin
          if (dly_q == '0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
          end else begin
            dly_q <= dly_q - DW'(1);
          end
        end
        // A measurement arriving on the last waiting cycle beats the timeout.
        WAIT: begin
          if (meas_valid_i[ch_q]) begin
            data_q  <= DATA_WIDTH'(resp_flags(meas_bit_i[ch_q], 1'b0, 1'b0));
            state_q <= RESP;
            ready_q <= 1'b1;
          end else if (tmo_q == TIMEOUT_LAST) begin
            data_q  <= DATA_WIDTH'(resp_flags(1'b0, 1'b1, 1'b0));
            state_q <= RESP;
            ready_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/fproc_meas_responder.sv
// Far end of the core-side fproc interface: keeps the latest measurement bit
// per readout channel and serves each core through its own independent port.
module fproc_meas_responder
  import fproc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int N_CORES        = 2,
  parameter int N_MEAS         = 8,
  parameter int RESP_LATENCY   = 2,
  parameter int TIMEOUT        = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CORES-1:0]                fproc_en_in,
  input  logic [N_CORES*FPROC_ID_WIDTH-1:0] fproc_id_in,
  input  logic [N_MEAS-1:0]                 meas_valid,
  input  logic [N_MEAS-1:0]                 meas_bit,
  output logic [N_CORES-1:0]                fproc_ready_out,
  output logic [N_CORES*DATA_WIDTH-1:0]     fproc_data_out,
  output logic [N_CORES-1:0]                fproc_busy_out
);

  logic [N_MEAS-1:0] latest_q;
  logic [N_MEAS-1:0] latest_d;

  always_comb begin
    latest_d = (latest_q & ~meas_valid) | (meas_bit & meas_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latest_q <= '0;
    end else begin
      latest_q <= latest_d;
    end
  end

  for (genvar i = 0; i < N_CORES; i++) begin : g_port
    fproc_core_port #(
      .DATA_WIDTH    (DATA_WIDTH),
      .FPROC_ID_WIDTH(FPROC_ID_WIDTH),
      .N_MEAS        (N_MEAS),
      .RESP_LATENCY  (RESP_LATENCY),
      .TIMEOUT       (TIMEOUT)
    ) u_port (
      .clk_i       (clk),
      .rst_ni      (reset),
      .en_i        (fproc_en_in[i]),
      .id_i        (fproc_id_in[FPROC_ID_WIDTH*i +: FPROC_ID_WIDTH]),
      .latest_i    (latest_q),
      .meas_valid_i(meas_valid),
      .meas_bit_i  (meas_bit),
      .ready_o     (fproc_ready_out[i]),
      .data_o      (fproc_data_out[DATA_WIDTH*i +: DATA_WIDTH]),
      .busy_o      (fproc_busy_out[i])
    );
  end

endmodule

// File: tb/tb_fproc_meas_responder.sv
// Scoreboard bench: a directed prologue followed by random traffic; expected
// responses come from a cycle-indexed model of the measurement history.
module tb_fproc_meas_responder;

  localparam int NC   = 2;
  localparam int DW   = 32;
  localparam int IW   = 8;
  localparam int NM   = 8;
  localparam int LAT  = 2;
  localparam int TO   = 16;
  localparam int NCYC = 640;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    fproc_en_in;
  logic [NC*IW-1:0] fproc_id_in;
  logic [NM-1:0]    meas_valid;
  logic [NM-1:0]    meas_bit;
  logic [NC-1:0]    fproc_ready_out;
  logic [NC*DW-1:0] fproc_data_out;
  logic [NC-1:0]    fproc_busy_out;

  fproc_meas_responder #(
    .DATA_WIDTH    (DW),
    .FPROC_ID_WIDTH(IW),
    .N_CORES       (NC),
    .N_MEAS        (NM),
    .RESP_LATENCY  (LAT),
    .TIMEOUT       (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fproc_en_in    (fproc_en_in),
    .fproc_id_in    (fproc_id_in),
    .meas_valid     (meas_valid),
    .meas_bit       (meas_bit),
    .fproc_ready_out(fproc_ready_out),
    .fproc_data_out (fproc_data_out),
    .fproc_busy_out (fproc_busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            core;
    int            cyc;
    logic [DW-1:0] data;
  } resp_t;

  resp_t expQ[$];

  bit [NM-1:0] mv[NCYC];
  bit [NM-1:0] mb[NCYC];
  bit          rstArr[NCYC];
  bit          enArr[NC][NCYC];
  bit [IW-1:0] idArr[NC][NCYC];
  bit          expBusy[NC][NCYC];
  int          freeAfter[NC];
  int          cur = -1;
  int          checks = 0;
  int          passes = 0;

  task automatic addReq(input int core, input int t, input bit [IW-1:0] id);
    enArr[core][t] = 1'b1;
    idArr[core][t] = id;
  endtask

  task automatic addMeas(input int t, input int ch, input bit v);
    mv[t][ch] = 1'b1;
    mb[t][ch] = v;
  endtask

  task automatic buildSchedule();
    rstArr[0] = 1'b1;
    rstArr[1] = 1'b1;
    rstArr[2] = 1'b1;
    addMeas(5, 3, 1'b1);
    addReq(0, 10, 8'h03);
    addMeas(14, 3, 1'b0);
    addReq(0, 14, 8'h03);
    addReq(1, 20, 8'h82);
    addMeas(20, 2, 1'b1);
    addMeas(30, 2, 1'b1);
    addReq(0, 40, 8'h85);
    addReq(0, 60, 8'h85);
    addMeas(76, 5, 1'b1);
    addReq(0, 80, 8'h0A);
    addReq(0, 81, 8'h0A);
    addMeas(85, 1, 1'b1);
    addReq(0, 90, 8'h81);
    addReq(1, 90, 8'h81);
    rstArr[95] = 1'b1;
    addReq(0, 100, 8'h01);
    addMeas(105, 3, 1'b1);
    addReq(0, 110, 8'h03);
    addReq(1, 110, 8'h03);
    for (int k = 120; k < NCYC - 41; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        rstArr[k] = 1'b1;
      end else begin
        for (int ch = 0; ch < NM; ch++) begin
          if ($urandom_range(0, 7) == 0) addMeas(k, ch, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < NC; i++) begin
          if ($urandom_range(0, 5) == 0)
            addReq(i, k, {1'($urandom_range(0, 1)), 7'($urandom_range(0, 9))});
        end
      end
    end
  endtask

  // Expected answer for a request at cycle t; rstAt >= 0 means a reset kills it.
  task automatic predict(input int t, input bit [IW-1:0] id, output int r,
                         output logic [DW-1:0] d, output int rstAt);
    int ch;
    bit v;
    ch = int'(id[IW-2:0]);
    d  = '0;
    if (ch >= NM) begin
      r    = t + LAT;
      d[2] = 1'b1;
    end else if (!id[IW-1]) begin
      v = 1'b0;
      for (int c = t - 1; c >= 0; c--) begin
        if (rstArr[c]) break;
        if (mv[c][ch]) begin
          v = mb[c][ch];
          break;
        end
      end
      r    = t + LAT;
      d[0] = v;
    end else begin
      r    = t + TO + 1;
      d[1] = 1'b1;
      for (int u = t + 1; u <= t + TO; u++) begin
        if (mv[u][ch]) begin
          r    = u + 1;
          d    = '0;
          d[0] = mb[u][ch];
          break;
        end
      end
    end
    rstAt = -1;
    for (int c = t + 1; c <= r; c++) begin
      if (rstArr[c]) begin
        rstAt = c;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int k);
    int            r;
    int            rstAt;
    logic [DW-1:0] d;
    resp_t         e;
    reset      = !rstArr[k];
    meas_valid = mv[k];
    meas_bit   = mb[k];
    for (int i = 0; i < NC; i++) begin
      fproc_en_in[i]           = enArr[i][k];
      fproc_id_in[i*IW +: IW]  = idArr[i][k];
      if (enArr[i][k] && k > freeAfter[i]) begin
        predict(k, idArr[i][k], r, d, rstAt);
        if (rstAt < 0) begin
          e.core = i;
          e.cyc  = r;
          e.data = d;
          expQ.push_back(e);
          for (int c = k + 1; c <= r; c++) expBusy[i][c] = 1'b1;
          freeAfter[i] = r;
        end else begin
          for (int c = k + 1; c < rstAt; c++) expBusy[i][c] = 1'b1;
          freeAfter[i] = rstAt;
        end
      end
    end
  endtask

  function automatic int findFirst(input int core);
    foreach (expQ[n]) begin
      if (expQ[n].core == core) return n;
    end
    return -1;
  endfunction

  task automatic checkOutput(input int k);
    int            idx;
    logic [DW-1:0] act;
    for (int i = 0; i < NC; i++) begin
      act = fproc_data_out[i*DW +: DW];
      checks++;
      if (fproc_busy_out[i] === expBusy[i][k]) passes++;
      else $display("[TB] FAIL busy core%0d cyc%0d: got %b want %b", i, k, fproc_busy_out[i], expBusy[i][k]);
      if (rstArr[k]) begin
        checks++;
        if (act === '0) passes++;
        else $display("[TB] FAIL reset_data core%0d cyc%0d: got %h want 0", i, k, act);
      end
      idx = findFirst(i);
      while (idx >= 0 && expQ[idx].cyc < k) begin
        checks++;
        $display("[TB] FAIL missed_ready core%0d: expected at cyc%0d data %h, ready not received", i, expQ[idx].cyc, expQ[idx].data);
        expQ.delete(idx);
        idx = findFirst(i);
      end
      if (fproc_ready_out[i] === 1'b1) begin
        checks++;
        if (idx < 0) begin
          $display("[TB] FAIL unexpected_ready core%0d cyc%0d data %h", i, k, act);
        end else begin
          if (expQ[idx].cyc == k && act === expQ[idx].data) passes++;
          else $display("[TB] FAIL response core%0d: got cyc%0d data %h want cyc%0d data %h", i, k, act, expQ[idx].cyc, expQ[idx].data);
          expQ.delete(idx);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (cur >= 0) checkOutput(cur);
  end

  initial begin
    reset       = 1'b0;
    fproc_en_in = '0;
    fproc_id_in = '0;
    meas_valid  = '0;
    meas_bit    = '0;
    for (int i = 0; i < NC; i++) freeAfter[i] = -1;
    buildSchedule();
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cur = k;
      applyStimulus(k);
    end
    @(posedge clk);
    #1;
    while (expQ.size() > 0) begin
      checks++;
      $display("[TB] FAIL never_ready core%0d: expected at cyc%0d data %h", expQ[0].core, expQ[0].cyc, expQ[0].data);
      void'(expQ.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
